// File: rtl/neurorisc_pkg.sv
// Shared NeuroRISC types: spike channel ids, ingress FSM states and the
// channel-search helper used by the spike ingress block.
package neurorisc_pkg;

   localparam int DATA_W       = 32;
   localparam int NUM_SPIKE_CH = 4;

   typedef logic [1:0] spike_ch_t;

   typedef enum logic {
      ING_IDLE,
      ING_SEND
   } ing_state_t;

   // Returns {found, ch}: the lowest set bit of mask at index >= from.
   function automatic logic [2:0] first_ch(input logic [NUM_SPIKE_CH-1:0] mask,
                                           input logic [2:0]              from);
      first_ch = 3'b000;
      for (int i = NUM_SPIKE_CH - 1; i >= 0; i--) begin
         if (mask[i] && (3'(i) >= from)) first_ch = {1'b1, 2'(i)};
      end
   endfunction

endpackage

// File: rtl/neurorisc_debounce.sv
// Step button front end: 2-flop synchronizer, stability-counter debounce and
// a one-cycle pulse on every 0->1 change of the debounced level.
module neurorisc_debounce #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic button_in,
   output logic level,
   output logic rise
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] cnt;

   // NOTE: sequential state is assigned with <= only, so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         cnt   <= '0;
         level <= 1'b0;
         rise  <= 1'b0;
      end else begin
         sync1 <= button_in;
         sync2 <= sync1;
         rise  <= 1'b0;
         if (sync2 == level) begin
            cnt <= '0;
         end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            level <= sync2;
            rise  <= sync2;
            cnt   <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/neurorisc_spike_ingress.sv
// Snapshots the four spike channels on each debounced step press and streams
// them as (channel, value) beats. SPIKE_INGRESS_SKIP_ZERO_EN drops zero channels.
module neurorisc_spike_ingress
   import neurorisc_pkg::*;
#(
   parameter int DATA_W          = neurorisc_pkg::DATA_W,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              button_in,
   input  logic [DATA_W-1:0] spike_a,
   input  logic [DATA_W-1:0] spike_b,
   input  logic [DATA_W-1:0] spike_c,
   input  logic [DATA_W-1:0] spike_d,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [1:0]        out_ch,
   output logic [DATA_W-1:0] out_data,
   output logic              busy,
   output logic              overrun,
   output logic [CNT_W-1:0]  step_count
);

   ing_state_t        state;
   ing_state_t        state_nxt;
   logic [DATA_W-1:0] spike_in [NUM_SPIKE_CH];
   logic [DATA_W-1:0] snap     [NUM_SPIKE_CH];
   spike_ch_t         ch;
   spike_ch_t         start_ch;
   spike_ch_t         adv_ch;
   logic              ch_valid;
   logic              ch_last;
   logic              btn_level;
   logic              btn_rise;
   logic              step;
   logic              xfer;

   neurorisc_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk      (clk),
      .rst_n    (rst_n),
      .button_in(button_in),
      .level    (btn_level),
      .rise     (btn_rise)
   );

   assign step     = btn_rise & btn_level;
   assign spike_in = '{spike_a, spike_b, spike_c, spike_d};
   assign xfer     = out_valid & out_ready;

`ifdef SPIKE_INGRESS_SKIP_ZERO_EN
   logic [NUM_SPIKE_CH-1:0] in_nz;
   logic [NUM_SPIKE_CH-1:0] snap_nz;
   logic [2:0]              first_in;
   logic [2:0]              next_snap;

   always_comb begin
      for (int i = 0; i < NUM_SPIKE_CH; i++) begin
         in_nz[i]   = (spike_in[i] != '0);
         snap_nz[i] = (snap[i] != '0);
      end
   end

   assign first_in  = first_ch(in_nz, 3'd0);
   assign next_snap = first_ch(snap_nz, {1'b0, ch} + 3'd1);
   assign start_ch  = first_in[1:0];
   assign adv_ch    = next_snap[1:0];
   assign ch_valid  = snap_nz[ch];
   assign ch_last   = ~next_snap[2];
`else
   assign start_ch = '0;
   assign adv_ch   = ch + 2'd1;
   assign ch_valid = 1'b1;
   assign ch_last  = (ch == 2'(NUM_SPIKE_CH - 1));
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ING_IDLE;
      else        state <= state_nxt;
   end

   // NOTE: a default assignment first keeps every path driven, so no latch.
   always_comb begin
      state_nxt = state;
      case (state)
         ING_IDLE: if (step) state_nxt = ING_SEND;
         ING_SEND: if (!ch_valid || (xfer && ch_last)) state_nxt = ING_IDLE;
         default:  state_nxt = ING_IDLE;
      endcase
   end

   always_comb begin
      busy      = (state == ING_SEND);
      out_valid = busy & ch_valid;
      out_ch    = ch;
      out_data  = snap[ch];
   end

   // NOTE: the four-entry snapshot is plain flops, reset so out_data reads 0
   // after reset; a large RAM-style array would not be reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_SPIKE_CH; i++) snap[i] <= '0;
         ch         <= '0;
         step_count <= '0;
         overrun    <= 1'b0;
      end else begin
         if (state == ING_IDLE && step) begin
            snap       <= spike_in;
            ch         <= start_ch;
            step_count <= step_count + CNT_W'(1);
         end else if (state == ING_SEND && xfer) begin
            ch <= ch_last ? '0 : adv_ch;
         end
         // A press while a snapshot is still draining is dropped but flagged.
         if (state == ING_SEND && step) overrun <= 1'b1;
      end
   end

endmodule

// File: tb/tb_neurorisc_spike_ingress.sv
// Scoreboard bench for neurorisc_spike_ingress; expectations follow
// SPIKE_INGRESS_SKIP_ZERO_EN when the bench and RTL are built with it.
module tb_neurorisc_spike_ingress;

   localparam int DW    = 32;
   localparam int DEB   = 4;
   localparam int CW    = 4;
`ifdef SPIKE_INGRESS_SKIP_ZERO_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif

   typedef struct packed {
      logic [1:0]    ch;
      logic [DW-1:0] data;
   } beat_t;

   logic          clk;
   logic          rst_n;
   logic          button_in;
   logic [DW-1:0] spike_a, spike_b, spike_c, spike_d;
   logic          out_valid;
   logic          out_ready;
   logic [1:0]    out_ch;
   logic [DW-1:0] out_data;
   logic          busy;
   logic          overrun;
   logic [CW-1:0] step_count;

   beat_t         sb[$];
   int            total = 0;
   int            bad = 0;
   int            beat_cnt = 0;
   logic [CW-1:0] exp_count = '0;
   int            exp_busy = 0;

   neurorisc_spike_ingress #(
      .DATA_W(DW), .DEBOUNCE_CYCLES(DEB), .CNT_W(CW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .button_in(button_in),
      .spike_a(spike_a), .spike_b(spike_b), .spike_c(spike_c), .spike_d(spike_d),
      .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
      .out_data(out_data), .busy(busy), .overrun(overrun), .step_count(step_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   // Beats are compared on the falling edge in the cycle they transfer.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         beat_t e;
         beat_cnt++;
         check("beat_expected", 64'(sb.size() != 0), 1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("beat_ch", out_ch, e.ch);
            check("beat_data", out_data, e.data);
         end
      end
   end

   // Set the channels, push the beats this snapshot must produce.
   task automatic arm(input logic [DW-1:0] a, b, c, d);
      logic [DW-1:0] v [4];
      int nnz;
      v = '{a, b, c, d};
      spike_a = a; spike_b = b; spike_c = c; spike_d = d;
      nnz = 0;
      for (int i = 0; i < 4; i++) begin
         if (!SKIP || v[i] != '0) begin
            sb.push_back('{ch: 2'(i), data: v[i]});
            nnz++;
         end
      end
      exp_busy  = (nnz == 0) ? 1 : nnz;
      exp_count = exp_count + CW'(1);
   endtask

   task automatic wait_busy(output int lat);
      lat = 0;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk); #1;
         lat++;
         if (busy) return;
      end
      check("busy_rise", busy, 1);
      lat = -1;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 60; i++) begin
         if (!busy) return;
         @(posedge clk); #1;
      end
      check("busy_fall", busy, 0);
   endtask

   task automatic busy_len(output int n);
      n = 1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (busy) n++;
         else return;
      end
   endtask

   task automatic release_button();
      button_in = 1'b0;
      repeat (DEB + 6) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      button_in = 1'b0;
      out_ready = 1'b1;
      sb.delete();
      exp_count = '0;
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic press_and_drain(input logic [DW-1:0] a, b, c, d, input string tag);
      int lat, n;
      arm(a, b, c, d);
      button_in = 1'b1;
      wait_busy(lat);
      busy_len(n);
      check({tag, "_busy_len"}, n, exp_busy);
      wait_idle();
      check({tag, "_count"}, step_count, exp_count);
      check({tag, "_drained"}, sb.size(), 0);
      release_button();
   endtask

   initial begin
      int lat, n, start;
      spike_a = '0; spike_b = '0; spike_c = '0; spike_d = '0;
      do_reset();

      check("rst_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_overrun", overrun, 0);
      check("rst_count", step_count, 0);
      check("rst_ch", out_ch, 0);
      check("rst_data", out_data, 0);

      // Clean press: pulse DEB+2 cycles after the edge, busy one cycle later.
      arm(10, 1, 2, 5);
      button_in = 1'b1;
      wait_busy(lat);
      check("step_latency", lat, DEB + 3);
      check("first_valid", out_valid, 1);
      busy_len(n);
      check("clean_busy_len", n, exp_busy);
      check("clean_count", step_count, 1);
      check("clean_overrun", overrun, 0);
      check("clean_drained", sb.size(), 0);
      release_button();

      // Bounce shorter than the debounce window yields a single step.
      do_reset();
      arm(3, 4, 6, 7);
      for (int i = 0; i < 10; i++) begin
         button_in = ~button_in;
         repeat (2) @(posedge clk);
      end
      #1;
      check("bounce_no_step", step_count, 0);
      button_in = 1'b1;
      wait_busy(lat);
      wait_idle();
      repeat (DEB + 4) @(posedge clk);
      #1;
      check("bounce_count", step_count, 1);
      check("bounce_drained", sb.size(), 0);
      release_button();

      // Backpressure: beat (0,10) holds while out_ready is low.
      do_reset();
      out_ready = 1'b0;
      arm(10, 1, 2, 5);
      button_in = 1'b1;
      wait_busy(lat);
      for (int i = 0; i < 3; i++) begin
         check("bp_valid", out_valid, 1);
         check("bp_ch", out_ch, 0);
         check("bp_data", out_data, 10);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_advanced", out_ch, 1);
      wait_idle();
      check("bp_overrun", overrun, 0);
      release_button();

      // Overrun: second press lands while beat 2 is stalled.
      out_ready = 1'b0;
      arm(7, 8, 9, 11);
      button_in = 1'b1;
      wait_busy(lat);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      release_button();
      spike_a = 99; spike_b = 99; spike_c = 99; spike_d = 99;
      button_in = 1'b1;
      repeat (DEB + 6) @(posedge clk);
      #1;
      check("ovr_flag", overrun, 1);
      check("ovr_count", step_count, exp_count);
      check("ovr_busy", busy, 1);
      check("ovr_ch", out_ch, 1);
      check("ovr_data", out_data, 8);
      out_ready = 1'b1;
      wait_idle();
      check("ovr_drained", sb.size(), 0);
      check("ovr_sticky", overrun, 1);
      release_button();

      // Zero channels (skipped only in the SKIP_ZERO build).
      do_reset();
      press_and_drain(10, 0, 0, 5, "zero_ad");
      press_and_drain(0, 0, 0, 0, "zero_all");

      // Reset after the second beat: immediate reset values, no more beats.
      do_reset();
      arm(21, 22, 23, 24);
      button_in = 1'b1;
      wait_busy(lat);
      start = beat_cnt;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (beat_cnt == start + 2) break;
      end
      check("mid_two_beats", beat_cnt, start + 2);
      rst_n = 1'b0;
      #1;
      check("mid_valid", out_valid, 0);
      check("mid_busy", busy, 0);
      check("mid_count", step_count, 0);
      check("mid_data", out_data, 0);
      button_in = 1'b0;
      sb.delete();
      exp_count = '0;
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      check("mid_no_more", beat_cnt, start + 2);
      check("mid_idle", busy, 0);

      // step_count wraps modulo 2^CNT_W.
      do_reset();
      for (int i = 0; i < (1 << CW); i++) begin
         arm(1, 2, 3, 4);
         button_in = 1'b1;
         wait_busy(lat);
         wait_idle();
         check("wrap_count", step_count, exp_count);
         release_button();
      end
      check("wrap_zero", step_count, 0);
      check("final_drained", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
